bs_rr_arbtr_bcst: RTL

- Parametrised successor of the single-bus generator/arbiter.
- Arbitrates among `drvrs` device FIFOs, moves one packet at a time from source to destination device, and supports broadcast.
- Adds features the previous generation lacks:
  - selectable round-robin or fixed-priority arbitration;
  - per-destination backpressure (`full`);
  - stall timeout with packet drop;
  - error and drop reporting.
- Sits between the device-side FIFOs and the device receivers; it is the unit the bus testbench environment drives.

---
 rtl/bs_rr_arbtr_bcst_if.sv | 30 +++
 rtl/bs_rr_arbtr_bcst.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bs_rr_arbtr_bcst_if.sv
// Bus bundle between the device FIFOs/receivers and the packet arbiter.
// master = arbiter side, slave = device side.
interface bs_rr_arbtr_bcst_if #(
    parameter int unsigned pckg_sz = 32,
    parameter int unsigned drvrs   = 16
);
    localparam int unsigned GntW = (drvrs > 1) ? $clog2(drvrs) : 1;

    logic                            rr_mode;
    logic [drvrs-1:0]                pndng;
    logic [drvrs-1:0][pckg_sz-1:0]   d_pop;
    logic [drvrs-1:0]                pop;
    logic [drvrs-1:0]                full;
    logic [drvrs-1:0]                push;
    logic [drvrs-1:0][pckg_sz-1:0]   d_push;
    logic                            busy;
    logic [GntW-1:0]                 grant_id;
    logic                            err_drop;
    logic [15:0]                     drop_cnt;

    modport master (
        input  rr_mode, pndng, d_pop, full,
        output pop, push, d_push, busy, grant_id, err_drop, drop_cnt
    );

    modport slave (
        output rr_mode, pndng, d_pop, full,
        input  pop, push, d_push, busy, grant_id, err_drop, drop_cnt
    );
endinterface

// File: rtl/bs_rr_arbtr_bcst.sv
// Single-bus packet arbiter: round-robin or fixed-priority grant, one packet per
// IDLE->POP->ROUTE->PUSH pass, with broadcast, backpressure and stall-timeout drop.
module bs_rr_arbtr_bcst #(
    parameter int unsigned       pckg_sz   = 32,
    parameter int unsigned       drvrs     = 16,
    parameter int unsigned       id_w      = 8,
    parameter logic [id_w-1:0]   broadcast = {id_w{1'b1}},
    parameter int unsigned       tmo       = 255
) (
    input logic                clk,
    input logic                reset,
    bs_rr_arbtr_bcst_if.master bus_io
);
    localparam int unsigned GntW   = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam int unsigned StallW = $clog2(tmo + 1);

    typedef enum logic [1:0] {StIdle, StPop, StRoute, StPush} state_e;

    state_e              state_q, state_d;
    logic [GntW-1:0]     grant_q, grant_d;
    logic [GntW-1:0]     ptr_q, ptr_d;
    logic [pckg_sz-1:0]  pkt_q, pkt_d;
    logic [drvrs-1:0]    tgt_q, tgt_d;
    logic [StallW-1:0]   stall_q, stall_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic [id_w-1:0]     id;
    logic                blocked;
    logic                drop;
    logic                arb_vld;
    logic [GntW-1:0]     arb_gnt;
    logic [drvrs-1:0]    pop;
    logic [drvrs-1:0]    push;

    assign id      = pkt_q[pckg_sz-1 -: id_w];
    assign blocked = |(tgt_q & bus_io.full);

    // Round-robin scans upward from ptr+1 with wrap; fixed mode scans from 0.
    always_comb begin
        int unsigned pos;
        arb_vld = 1'b0;
        arb_gnt = '0;
        pos     = 0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            if (bus_io.rr_mode) begin
                pos = 32'(ptr_q) + 1 + i;
                if (pos >= drvrs) pos = pos - drvrs;
            end else begin
                pos = i;
            end
            if (!arb_vld && bus_io.pndng[GntW'(pos)]) begin
                arb_vld = 1'b1;
                arb_gnt = GntW'(pos);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        pkt_d   = pkt_q;
        tgt_d   = tgt_q;
        stall_d = stall_q;
        drop    = 1'b0;
        pop     = '0;
        push    = '0;
        unique case (state_q)
            StIdle: begin
                if (arb_vld) begin
                    grant_d = arb_gnt;
                    state_d = StPop;
                end
            end
            StPop: begin
                pop[grant_q] = 1'b1;
                pkt_d        = bus_io.d_pop[grant_q];
                ptr_d        = grant_q;
                state_d      = StRoute;
            end
            StRoute: begin
                stall_d = '0;
                if (id == broadcast) begin
                    tgt_d          = '1;
                    tgt_d[grant_q] = 1'b0;
                    state_d        = StPush;
                end else if (32'(id) < drvrs) begin
                    tgt_d              = '0;
                    tgt_d[GntW'(id)]   = 1'b1;
                    state_d            = StPush;
                end else begin
                    drop    = 1'b1;
                    state_d = StIdle;
                end
            end
            StPush: begin
                // All-or-nothing: any full target holds back the whole set.
                if (!blocked) begin
                    push    = tgt_q;
                    state_d = StIdle;
                end else if (stall_q >= StallW'(tmo)) begin
                    drop    = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ptr_q      <= GntW'(drvrs - 1);
            pkt_q      <= '0;
            tgt_q      <= '0;
            stall_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            pkt_q      <= pkt_d;
            tgt_q      <= tgt_d;
            stall_q    <= stall_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        bus_io.d_push = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            if (push[i]) bus_io.d_push[i] = pkt_q;
        end
    end

    assign bus_io.pop      = pop;
    assign bus_io.push     = push;
    assign bus_io.busy     = (state_q != StIdle);
    assign bus_io.grant_id = grant_q;
    assign bus_io.err_drop = drop;
    assign bus_io.drop_cnt = drop_cnt_q;
endmodule
